top_design: RTL and testbench
=============================

TOP_DESIGN -- requirements
Module: top_design

Interface
REQ-001 Parameter EXP_W, default 8, exponent width; only the default is supported.
REQ-002 Parameter MAN_W, default 23, fraction width; only the default is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 load  input  1  operand-capture strobe, sampled on the rising edge of clk.
REQ-006 op  input  1  operation select: 0 = numar1 + numar2, 1 = numar1 - numar2; captured together with the operands.
REQ-007 numar1  input  32  IEEE-754 single-precision operand A.
REQ-008 numar2  input  32  IEEE-754 single-precision operand B.
REQ-009 numar  output  32  registered IEEE-754 single-precision result.

Function
REQ-010 The block SHALL be a 4-stage pipelined FP32 adder/subtractor with one new operation accepted per cycle:
- S1: unpack, swap so |A| >= |B|, exponent difference.
- S2: align the smaller mantissa, producing guard/round/sticky bits, then add or subtract.
- S3: leading-zero normalize and adjust the exponent.
- S4: round to nearest-even, pack, and register into numar.
REQ-011 When load=1 at an edge, the operands and op SHALL be captured with a valid flag; when load=0, a bubble (valid=0) SHALL enter.
REQ-012 Latency: operands captured at edge k SHALL appear on numar immediately after edge k+4.
REQ-013 numar SHALL update only when a valid token leaves S4 and SHALL otherwise hold its value.
REQ-014 Back-to-back loads SHALL produce back-to-back results in order.
REQ-015 Subtraction SHALL be implemented as addition with the sign of numar2 inverted.
REQ-016 Subnormal inputs SHALL be treated as signed zero, and subnormal results SHALL be flushed to +0.
REQ-017 Exact cancellation SHALL produce +0x00000000; (-0) + (-0) SHALL produce 0x80000000.
REQ-018 Exponent overflow after rounding SHALL produce correctly signed infinity (0x7F800000 / 0xFF800000).
REQ-019 Any NaN input, or inf - inf (after the effective op), SHALL produce canonical NaN 0x7FC00000.
REQ-020 Infinity combined with a finite value SHALL produce that infinity.
REQ-021 Exponent differences greater than 26 SHALL fold the whole smaller mantissa into sticky.

Reset
REQ-022 While reset is low, all valid flags SHALL clear and numar SHALL be 32'h00000000, asynchronously.
REQ-023 Reset asserted mid-operation SHALL discard every in-flight token; no result from before the reset SHALL ever appear.
REQ-024 Pipeline data registers other than valid flags and numar need no reset.

Configuration
REQ-025 With macro TOP_DESIGN_VALID_OUT_EN defined, the block SHALL add output port numar_valid (1 bit).
- numar_valid SHALL be high for exactly one cycle after each edge on which numar updates.
- numar_valid SHALL reset to 0.
REQ-026 Without TOP_DESIGN_VALID_OUT_EN, the port SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-027 Package top_design_pkg SHALL hold:
- an FP32 struct typedef (sign, exponent, fraction);
- the BIAS=127, EXP_MAX=255 and QNAN=32'h7FC00000 constants;
- a per-stage pipeline-register struct typedef.
REQ-028 Leading-zero count and normalize shift SHALL live in one sub-module, fp_normalizer, instantiated in S3.

Verification
REQ-029 Load 0x3F800000 + 0x40000000, op=0 -> numar=0x40400000 exactly 4 edges after the load edge, then held.
REQ-030 Load 0x40800000, 0x40A00000, op=1 -> numar=0xBF800000 after 4 edges; 0x40A00000 - 0x40A00000 -> 0x00000000.
REQ-031 Consecutive loads of 1.0+2.0, 4.0-5.0 and 0x3F800000+0x33800000 (tie case) -> 0x40400000, 0xBF800000, 0x3F800000 on consecutive cycles.
REQ-032 Specials:
- 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000;
- 0x7F800000-0x7F800000 -> 0x7FC00000;
- 0x7FC00001+1.0 -> 0x7FC00000;
- 0x00000001+0x00000000 -> 0x00000000.
REQ-033 Load 1.0+2.0, assert reset 2 cycles later, release -> numar stays 0x00000000 and never becomes 0x40400000.
REQ-034 With TOP_DESIGN_VALID_OUT_EN, numar_valid pulses exactly once per loaded operation, aligned with each numar update in REQ-029 to REQ-031.

Source files
------------

// File: rtl/top_design_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_design_pkg
// Description : Shared types and constants for the pipelined FP32
//               adder/subtractor (operand format, special values and the
//               per-stage pipeline register layouts).
// Revision    : 1.0 - initial release
// ============================================================================
package top_design_pkg;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    // IEEE-754 single-precision field layout
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } fp32_t;

    // Captured operands (input register)
    typedef struct packed {
        logic  op;
        fp32_t a;
        fp32_t b;
    } s0_t;

    // After unpack/swap: larger operand first, exponent difference ready
    typedef struct packed {
        logic        special;
        logic [31:0] special_val;
        logic        sign;
        logic        sub;
        logic [7:0]  exp;
        logic [23:0] man_l;
        logic [23:0] man_s;
        logic [7:0]  ediff;
    } s1_t;

    // After alignment and add/subtract: {carry, hidden, frac[22:0], G, R, S}
    typedef struct packed {
        logic        special;
        logic [31:0] special_val;
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] sum;
    } s2_t;

    // After normalization: {hidden, frac[22:0], G, R, S}
    typedef struct packed {
        logic        special;
        logic [31:0] special_val;
        logic        zero;
        logic        sign;
        logic [9:0]  exp;
        logic [26:0] mant;
    } s3_t;

    // Real-valued exponent of a normal number (used when reasoning about ranges)
    function automatic int unbiased_exp(input logic [7:0] e);
        return int'(e) - BIAS;
    endfunction

endpackage : top_design_pkg
`default_nettype wire

// File: rtl/top_design_fp_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalizer
// Description : Leading-zero count over a 27-bit mantissa/GRS vector and the
//               matching left shift that brings the leading one to bit 26.
//               An all-zero input reports a count of 27 and a zero output.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalizer (
    input  logic [26:0] i_val,
    output logic [4:0]  o_lzc,
    output logic [26:0] o_val
);

    // Highest set bit wins: later (higher) iterations override lower ones
    always_comb begin
        o_lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (i_val[i]) begin
                o_lzc = 5'(26 - i);
            end
        end
        o_val = i_val << o_lzc;
    end

endmodule : fp_normalizer
`default_nettype wire

// File: rtl/top_design.sv
`default_nettype none
// ============================================================================
// Module      : top_design
// Description : 4-stage pipelined IEEE-754 single-precision adder/subtractor.
//               S1 unpack/swap, S2 align + add/sub, S3 normalize, S4 round
//               to nearest-even and pack into numar. Subnormals are flushed
//               to zero on input and output.
// Config      : TOP_DESIGN_VALID_OUT_EN - adds the numar_valid output pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module top_design
    import top_design_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   numar1,
    input  logic [EXP_W+MAN_W:0]   numar2,
    output logic [EXP_W+MAN_W:0]   numar
`ifdef TOP_DESIGN_VALID_OUT_EN
    ,
    output logic                   numar_valid
`endif
);

    logic        r_v0, r_v1, r_v2, r_v3;
    s0_t         r_s0;
    s1_t         r_s1;
    s2_t         r_s2;
    s3_t         r_s3;
    logic [31:0] r_numar;

    // ------------------------------------------------------------------
    // S1: unpack, flush subnormals, resolve specials, swap, exp difference
    // ------------------------------------------------------------------
    fp32_t       w_a, w_b;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [23:0] w_ma, w_mb;
    logic        w_swap;
    logic        w_special;
    logic [31:0] w_special_val;
    s1_t         w_s1;

    assign w_a = r_s0.a;
    assign w_b = '{sign: r_s0.b.sign ^ r_s0.op, exponent: r_s0.b.exponent,
                   fraction: r_s0.b.fraction};

    assign w_a_zero = (w_a.exponent == 8'd0);
    assign w_b_zero = (w_b.exponent == 8'd0);
    assign w_a_nan  = (w_a.exponent == 8'(EXP_MAX)) && (w_a.fraction != 23'd0);
    assign w_b_nan  = (w_b.exponent == 8'(EXP_MAX)) && (w_b.fraction != 23'd0);
    assign w_a_inf  = (w_a.exponent == 8'(EXP_MAX)) && (w_a.fraction == 23'd0);
    assign w_b_inf  = (w_b.exponent == 8'(EXP_MAX)) && (w_b.fraction == 23'd0);
    assign w_ma     = w_a_zero ? 24'd0 : {1'b1, w_a.fraction};
    assign w_mb     = w_b_zero ? 24'd0 : {1'b1, w_b.fraction};
    assign w_swap   = {w_b.exponent, w_mb} > {w_a.exponent, w_ma};

    // Special results bypass the arithmetic path; two zeros keep the AND of signs
    always_comb begin
        w_special     = w_a_nan | w_b_nan | w_a_inf | w_b_inf | (w_a_zero & w_b_zero);
        w_special_val = {w_a.sign & w_b.sign, 31'd0};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
            w_special_val = QNAN;
        end else if (w_a_inf) begin
            w_special_val = {w_a.sign, 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            w_special_val = {w_b.sign, 8'hFF, 23'd0};
        end
    end

    // Order the operands so the larger magnitude drives sign and exponent
    always_comb begin
        w_s1.special     = w_special;
        w_s1.special_val = w_special_val;
        w_s1.sub         = w_a.sign ^ w_b.sign;
        if (w_swap) begin
            w_s1.sign  = w_b.sign;
            w_s1.exp   = w_b.exponent;
            w_s1.man_l = w_mb;
            w_s1.man_s = w_ma;
            w_s1.ediff = w_b.exponent - w_a.exponent;
        end else begin
            w_s1.sign  = w_a.sign;
            w_s1.exp   = w_a.exponent;
            w_s1.man_l = w_ma;
            w_s1.man_s = w_mb;
            w_s1.ediff = w_a.exponent - w_b.exponent;
        end
    end

    // ------------------------------------------------------------------
    // S2: align smaller mantissa with G/R/S, then add or subtract
    // ------------------------------------------------------------------
    logic [49:0] w_ext;
    logic        w_far;
    logic [26:0] w_small, w_large;
    s2_t         w_s2;

    assign w_ext   = {r_s1.man_s, 26'd0} >> r_s1.ediff;
    // Beyond 26 positions every bit of the smaller mantissa lands in sticky
    assign w_far   = (r_s1.ediff > 8'd26);
    assign w_small = w_far ? {26'd0, |r_s1.man_s} : {w_ext[49:24], |w_ext[23:0]};
    assign w_large = {r_s1.man_l, 3'b000};

    always_comb begin
        w_s2.special     = r_s1.special;
        w_s2.special_val = r_s1.special_val;
        w_s2.sign        = r_s1.sign;
        w_s2.exp         = r_s1.exp;
        w_s2.sum         = r_s1.sub ? ({1'b0, w_large} - {1'b0, w_small})
                                    : ({1'b0, w_large} + {1'b0, w_small});
    end

    // ------------------------------------------------------------------
    // S3: normalize (carry right-shift or leading-zero left-shift)
    // ------------------------------------------------------------------
    logic [4:0]  w_lzc;
    logic [26:0] w_norm;
    logic [9:0]  w_exp_n;
    logic        w_uflow;
    s3_t         w_s3;

    fp_normalizer u_norm (
        .i_val (r_s2.sum[26:0]),
        .o_lzc (w_lzc),
        .o_val (w_norm)
    );

    assign w_exp_n = r_s2.sum[27] ? ({2'b00, r_s2.exp} + 10'd1)
                                  : ({2'b00, r_s2.exp} - {5'd0, w_lzc});
    assign w_uflow = ($signed(w_exp_n) < $signed(10'd1));

    // Exact cancellation and subnormal results both become +0 downstream
    always_comb begin
        w_s3.special     = r_s2.special;
        w_s3.special_val = r_s2.special_val;
        w_s3.zero        = (r_s2.sum == 28'd0) | w_uflow;
        w_s3.sign        = r_s2.sign;
        w_s3.exp         = w_exp_n;
        w_s3.mant        = r_s2.sum[27] ? {r_s2.sum[27:2], r_s2.sum[1] | r_s2.sum[0]}
                                        : w_norm;
    end

    // ------------------------------------------------------------------
    // S4: round to nearest-even, detect overflow, pack
    // ------------------------------------------------------------------
    logic        w_round_up;
    logic [24:0] w_m25;
    logic [9:0]  w_exp_f;
    logic [22:0] w_frac;
    logic [31:0] w_result;

    assign w_round_up = r_s3.mant[2] & (r_s3.mant[1] | r_s3.mant[0] | r_s3.mant[3]);
    assign w_m25      = {1'b0, r_s3.mant[26:3]} + {24'd0, w_round_up};
    assign w_exp_f    = r_s3.exp + {9'd0, w_m25[24]};
    assign w_frac     = w_m25[24] ? w_m25[23:1] : w_m25[22:0];

    always_comb begin
        w_result = {r_s3.sign, w_exp_f[7:0], w_frac};
        if (r_s3.special) begin
            w_result = r_s3.special_val;
        end else if (r_s3.zero) begin
            w_result = 32'd0;
        end else if (w_exp_f >= 10'(EXP_MAX)) begin
            w_result = {r_s3.sign, 8'hFF, 23'd0};
        end
    end

    // Valid flags and the result register clear asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_numar <= 32'd0;
        end else begin
            r_v0 <= load;
            r_v1 <= r_v0;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_v3) begin
                r_numar <= w_result;
            end
        end
    end

    // Pipeline data registers advance every cycle and need no reset
    always_ff @(posedge clk) begin
        r_s0 <= '{op: op, a: fp32_t'(numar1), b: fp32_t'(numar2)};
        r_s1 <= w_s1;
        r_s2 <= w_s2;
        r_s3 <= w_s3;
    end

    assign numar = r_numar;

`ifdef TOP_DESIGN_VALID_OUT_EN
    logic r_out_valid;

    // One-cycle pulse following every update of numar
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v3;
        end
    end

    assign numar_valid = r_out_valid;
`endif

endmodule : top_design
`default_nettype wire

// File: tb/tb_top_design.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_design
// Description : Directed self-checking bench for the pipelined FP32
//               adder/subtractor top_design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_design;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        op;
    logic [31:0] numar1;
    logic [31:0] numar2;
    logic [31:0] numar;
`ifdef TOP_DESIGN_VALID_OUT_EN
    logic        numar_valid;
`endif

    int tests = 0;
    int fails = 0;

    top_design dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .op     (op),
        .numar1 (numar1),
        .numar2 (numar2),
        .numar  (numar)
`ifdef TOP_DESIGN_VALID_OUT_EN
        ,
        .numar_valid (numar_valid)
`endif
    );

    always #5 clk = ~clk;

    // Present one operation so it is captured on the next rising edge
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic o);
        @(negedge clk);
        numar1 = a;
        numar2 = b;
        op     = o;
        load   = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        load   = 1'b0;
        op     = 1'b0;
        numar1 = 32'd0;
        numar2 = 32'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (numar !== 32'h00000000) begin
            fails++;
            $display("FAIL reset_numar: got %h expected %h", numar, 32'h0);
        end
`ifdef TOP_DESIGN_VALID_OUT_EN
        tests++;
        if (numar_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b expected 0", numar_valid);
        end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    // 1.0 + 2.0 with exact latency and hold checks
    task automatic test_add();
        logic [31:0] exp_v;
        drive(32'h3F800000, 32'h40000000, 1'b0);
        idle();
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            exp_v = (i >= 4) ? 32'h40400000 : 32'h00000000;
            tests++;
            if (numar !== exp_v) begin
                fails++;
                $display("FAIL add_lat cycle %0d: got %h expected %h", i, numar, exp_v);
            end
`ifdef TOP_DESIGN_VALID_OUT_EN
            tests++;
            if (numar_valid !== (i == 4)) begin
                fails++;
                $display("FAIL add_valid cycle %0d: got %b expected %b", i, numar_valid, (i == 4));
            end
`endif
        end
    endtask

    // 4.0 - 5.0 then 5.0 - 5.0
    task automatic test_sub();
        logic [31:0] exp_v;
        drive(32'h40800000, 32'h40A00000, 1'b1);
        idle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp_v = (i == 4) ? 32'hBF800000 : 32'h40400000;
            tests++;
            if (numar !== exp_v) begin
                fails++;
                $display("FAIL sub_lat cycle %0d: got %h expected %h", i, numar, exp_v);
            end
        end
        drive(32'h40A00000, 32'h40A00000, 1'b1);
        idle();
        repeat (4) @(negedge clk);
        tests++;
        if (numar !== 32'h00000000) begin
            fails++;
            $display("FAIL sub_cancel: got %h expected %h", numar, 32'h0);
        end
    endtask

    // Three consecutive loads produce three consecutive results
    task automatic test_back_to_back();
        logic [31:0] exp_q [0:4];
        exp_q[0] = 32'h00000000;
        exp_q[1] = 32'h40400000;
        exp_q[2] = 32'hBF800000;
        exp_q[3] = 32'h3F800000;
        exp_q[4] = 32'h3F800000;
        drive(32'h3F800000, 32'h40000000, 1'b0);
        drive(32'h40800000, 32'h40A00000, 1'b1);
        drive(32'h3F800000, 32'h33800000, 1'b0);
        idle();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            tests++;
            if (numar !== exp_q[i]) begin
                fails++;
                $display("FAIL b2b step %0d: got %h expected %h", i, numar, exp_q[i]);
            end
`ifdef TOP_DESIGN_VALID_OUT_EN
            tests++;
            if (numar_valid !== (i >= 1 && i <= 3)) begin
                fails++;
                $display("FAIL b2b_valid step %0d: got %b expected %b", i, numar_valid, (i >= 1 && i <= 3));
            end
`endif
        end
    endtask

    // Overflow, NaN, infinity and flushed-subnormal cases
    task automatic test_specials();
        logic [31:0] va [0:6];
        logic [31:0] vb [0:6];
        logic        vo [0:6];
        logic [31:0] ve [0:6];
        va[0] = 32'h7F7FFFFF; vb[0] = 32'h7F7FFFFF; vo[0] = 1'b0; ve[0] = 32'h7F800000;
        va[1] = 32'h7F800000; vb[1] = 32'h7F800000; vo[1] = 1'b1; ve[1] = 32'h7FC00000;
        va[2] = 32'h7FC00001; vb[2] = 32'h3F800000; vo[2] = 1'b0; ve[2] = 32'h7FC00000;
        va[3] = 32'h00000001; vb[3] = 32'h00000000; vo[3] = 1'b0; ve[3] = 32'h00000000;
        va[4] = 32'h80000000; vb[4] = 32'h80000000; vo[4] = 1'b0; ve[4] = 32'h80000000;
        va[5] = 32'h3F800000; vb[5] = 32'h7F800000; vo[5] = 1'b1; ve[5] = 32'hFF800000;
        va[6] = 32'hFF7FFFFF; vb[6] = 32'h7F7FFFFF; vo[6] = 1'b1; ve[6] = 32'hFF800000;
        for (int k = 0; k < 7; k++) begin
            drive(va[k], vb[k], vo[k]);
            idle();
            repeat (4) @(negedge clk);
            tests++;
            if (numar !== ve[k]) begin
                fails++;
                $display("FAIL special %0d: got %h expected %h", k, numar, ve[k]);
            end
        end
    endtask

    // Reset two cycles after a load discards the in-flight result
    task automatic test_reset_mid();
        drive(32'h3F800000, 32'h40000000, 1'b0);
        drive(32'h40000000, 32'h40400000, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        drive(32'h3F800000, 32'h40000000, 1'b0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (numar !== 32'h00000000) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h", numar, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (numar !== 32'h00000000) begin
                fails++;
                $display("FAIL reset_flush cycle %0d: got %h expected %h", i, numar, 32'h0);
            end
`ifdef TOP_DESIGN_VALID_OUT_EN
            tests++;
            if (numar_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_flush_valid cycle %0d: got %b expected 0", i, numar_valid);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_specials();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_top_design
`default_nettype wire
